// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A request is
//   granted in IDLE, its operands/opcode are registered onto the ALU inputs for
//   one EXEC cycle, and the ALU result is captured into a response register that
//   is held until the owning requester acknowledges it. Ties between the two
//   requesters are broken round-robin.
//
// Ports
//   CLK, Reset_n            clock, asynchronous active-low reset
//   Req0/1, A0/1, B0/1,     per-requester request, operands and opcode
//   Op0/1
//   Gnt0/1                  request accepted this cycle (combinational, IDLE)
//   RespValid0/1, RespAck0/1 per-requester response handshake
//   Result, Ovf, Err        shared held response (data, overflow, bad opcode)
//   Busy                    an operation is in flight (state != IDLE)
//   a, b, ALUOp             registered ALU operand/opcode drive
//   ALUOut, Overflow        ALU result and overflow flag
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    input  logic [OPW-1:0]   Op0,
    input  logic [OPW-1:0]   Op1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             RespValid0,
    output logic             RespValid1,
    input  logic             RespAck0,
    input  logic             RespAck1,
    output logic [WIDTH-1:0] Result,
    output logic             Ovf,
    output logic             Err,
    output logic             Busy,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [OPW-1:0]   ALUOp,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             Overflow
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(6);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_reg;
    logic             last_gnt_reg;   // requester served most recently
    logic             owner_reg;      // requester owning the in-flight op
    logic             illegal_reg;    // in-flight op had an unsupported opcode
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [OPW-1:0]   op_reg;
    logic [WIDTH-1:0] result_reg;
    logic             ovf_reg;
    logic             err_reg;
    logic [1:0]       resp_valid_reg;

    logic             any_req;
    logic             win1;           // requester 1 wins this cycle's arbitration
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OPW-1:0]   sel_op;
    logic             sel_legal;
    logic             owner_ack;
    logic             arith_op;

    always_comb begin
        any_req = Req0 | Req1;
        // Requester 1 wins when alone, or on a tie when requester 0 went last.
        win1    = Req1 & (~Req0 | ~last_gnt_reg);
        sel_a   = win1 ? A1 : A0;
        sel_b   = win1 ? B1 : B0;
        sel_op  = win1 ? Op1 : Op0;
        case (sel_op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR: sel_legal = 1'b1;
            default:                               sel_legal = 1'b0;
        endcase
        owner_ack = owner_reg ? RespAck1 : RespAck0;
        // Overflow is only meaningful for the arithmetic opcodes.
        arith_op  = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    end

    // Grants are suppressed while reset is held: nothing would be captured.
    assign Gnt1 = (state_reg == IDLE) & Reset_n & win1;
    assign Gnt0 = (state_reg == IDLE) & Reset_n & Req0 & ~win1;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= IDLE;
            last_gnt_reg   <= 1'b1;       // requester 0 wins the first tie
            owner_reg      <= 1'b0;
            illegal_reg    <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            op_reg         <= '0;
            result_reg     <= '0;
            ovf_reg        <= 1'b0;
            err_reg        <= 1'b0;
            resp_valid_reg <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        a_reg       <= sel_a;
                        b_reg       <= sel_b;
                        owner_reg   <= win1;
                        // An unsupported opcode still runs a harmless add.
                        op_reg      <= sel_legal ? sel_op : OP_ADD;
                        illegal_reg <= ~sel_legal;
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= illegal_reg ? '0 : ALUOut;
                    ovf_reg    <= (~illegal_reg & arith_op) ? Overflow : 1'b0;
                    err_reg    <= illegal_reg;
                    resp_valid_reg[owner_reg] <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (owner_ack) begin
                        resp_valid_reg <= 2'b00;
                        last_gnt_reg   <= owner_reg;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign a          = a_reg;
    assign b          = b_reg;
    assign ALUOp      = op_reg;
    assign Result     = result_reg;
    assign Ovf        = ovf_reg;
    assign Err        = err_reg;
    assign RespValid0 = resp_valid_reg[0];
    assign RespValid1 = resp_valid_reg[1];
    assign Busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Randomised and directed stimulus for alu_arbiter. Each requester has a
//   queue of pending operations; its Req is high while the queue is non-empty.
//   A driver process predicts grants and pushes expected responses into a
//   scoreboard; a monitor process compares every presented response and
//   acknowledges it after a random hold. A small ALU model drives ALUOut.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
    } op_t;

    typedef struct {
        int          owner;
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int          gcyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req0 = 1'b0, Req1 = 1'b0;
    logic [15:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic [2:0]  Op0 = '0, Op1 = '0;
    logic        Gnt0, Gnt1, RespValid0, RespValid1;
    logic        RespAck0 = 1'b0, RespAck1 = 1'b0;
    logic [15:0] Result;
    logic        Ovf, Err, Busy;
    logic [15:0] a, b;
    logic [2:0]  ALUOp;
    logic [15:0] ALUOut;
    logic        Overflow;
    logic        junk_ovf = 1'b0;   // ALU overflow value for non-arithmetic ops

    op_t  rq0[$];
    op_t  rq1[$];
    exp_t sb[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   model_last = 1;
    bit   model_idle = 1'b1;
    bit   exec_now = 1'b0;
    int   forced_hold = -1;
    int   age = 0;
    bit   acking = 1'b0;

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Op0(Op0), .Op1(Op1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .RespValid0(RespValid0), .RespValid1(RespValid1),
        .RespAck0(RespAck0), .RespAck1(RespAck1),
        .Result(Result), .Ovf(Ovf), .Err(Err), .Busy(Busy),
        .a(a), .b(b), .ALUOp(ALUOp),
        .ALUOut(ALUOut), .Overflow(Overflow)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Environment ALU.
    logic [15:0] alu_sum, alu_diff;
    assign alu_sum  = a + b;
    assign alu_diff = a - b;
    always_comb begin
        ALUOut   = 16'hDEAD;
        Overflow = junk_ovf;
        case (ALUOp)
            3'b000: begin
                ALUOut   = alu_sum;
                Overflow = (a[15] == b[15]) && (alu_sum[15] != a[15]);
            end
            3'b010: begin
                ALUOut   = alu_diff;
                Overflow = (a[15] != b[15]) && (alu_diff[15] != a[15]);
            end
            3'b100:  ALUOut = a & b;
            3'b101:  ALUOut = a ^ b;
            3'b110:  ALUOut = a | b;
            default: ALUOut = 16'hDEAD;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the requester should receive for an operation.
    function automatic exp_t model(input int owner, input op_t o);
        exp_t e;
        int   sa, sb2, s;
        e.owner = owner; e.res = '0; e.ovf = 1'b0; e.err = 1'b0; e.gcyc = 0;
        sa  = int'($signed(o.a));
        sb2 = int'($signed(o.b));
        case (o.op)
            3'b000: begin s = sa + sb2; e.res = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
            3'b010: begin s = sa - sb2; e.res = 16'(s); e.ovf = (s > 32767) || (s < -32768); end
            3'b100: e.res = o.a & o.b;
            3'b101: e.res = o.a ^ o.b;
            3'b110: e.res = o.a | o.b;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive_reqs();
        Req0 = (rq0.size() > 0);
        if (Req0) {A0, B0, Op0} = rq0[0];
        Req1 = (rq1.size() > 0);
        if (Req1) {A1, B1, Op1} = rq1[0];
    endtask

    // Driver: predicts grants, consumes granted ops, pushes expected responses.
    initial begin : driver
        op_t  o;
        exp_t e;
        logic e0, e1, granted;
        forever begin
            @(negedge CLK);
            granted = 1'b0;
            if (Reset_n) begin
                e0 = 1'b0; e1 = 1'b0;
                if (model_idle) begin
                    if (Req0 && Req1) begin
                        if (model_last == 0) e1 = 1'b1; else e0 = 1'b1;
                    end else begin
                        e0 = Req0; e1 = Req1;
                    end
                end
                check("gnt0", Gnt0, e0);
                check("gnt1", Gnt1, e1);
                if (e0 || e1) begin
                    if (e1) o = rq1.pop_front(); else o = rq0.pop_front();
                    e = model(e1 ? 1 : 0, o);
                    e.gcyc = cyc;
                    sb.push_back(e);
                    model_idle = 1'b0;
                    granted = 1'b1;
                    $display("[TB] grant req%0d a=%h b=%h op=%b", e1 ? 1 : 0, o.a, o.b, o.op);
                end
            end
            @(posedge CLK); #1;
            exec_now = granted;
            if (granted && Reset_n) begin
                check("exec_a", a, o.a);
                check("exec_b", b, o.b);
                check("exec_aluop", ALUOp, e.err ? 3'b000 : o.op);
                check("exec_busy", Busy, 1'b1);
            end
            drive_reqs();
        end
    end

    // Monitor: compares held responses and acknowledges them.
    initial begin : monitor
        exp_t e;
        int   wv;
        int   hold;
        hold = 0; wv = 0;
        forever begin
            @(negedge CLK);
            if (Reset_n) begin
                check("one_valid", RespValid0 & RespValid1, 1'b0);
                check("gnt_while_busy", Busy & (Gnt0 | Gnt1), 1'b0);
                if (RespValid0 || RespValid1) begin
                    wv = RespValid1 ? 1 : 0;
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_resp: got RespValid%0d=1 expected none", wv);
                        hold = 0;
                    end else begin
                        e = sb[0];
                        check("resp_owner", wv, e.owner);
                        check("resp_result", Result, e.res);
                        check("resp_ovf", Ovf, e.ovf);
                        check("resp_err", Err, e.err);
                        if (age == 0) begin
                            check("resp_latency", cyc - e.gcyc, 2);
                            hold = (forced_hold >= 0) ? forced_hold : $urandom_range(0, 3);
                            $display("[TB] resp req%0d result=%h ovf=%b err=%b", wv, Result, Ovf, Err);
                        end
                    end
                    if (age >= hold) begin
                        if (wv == 1) RespAck1 = 1'b1; else RespAck0 = 1'b1;
                        acking = 1'b1;
                    end else if ($urandom_range(0, 1) == 1) begin
                        // Non-owner ack must be ignored.
                        if (wv == 1) RespAck0 = 1'b1; else RespAck1 = 1'b1;
                    end
                    age++;
                end
            end
            @(posedge CLK); #1;
            if (acking && Reset_n) begin
                if (sb.size() > 0) void'(sb.pop_front());
                model_last = wv;
                model_idle = 1'b1;
                age = 0;
            end
            acking = 1'b0;
            RespAck0 = 1'b0;
            RespAck1 = 1'b0;
        end
    end

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0 || !model_idle) && n < maxc) begin
            @(posedge CLK);
            n++;
        end
        check("drain_in_time", n < maxc, 1'b1);
        @(posedge CLK); #2;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {Gnt0, Gnt1, RespValid0, RespValid1, Busy, Result, Ovf, Err, a, b, ALUOp}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        op_t o;
        int  n;
        // Both requesters pending from reset.
        rq0.push_back('{16'h7FFF, 16'h0001, 3'b000});
        rq1.push_back('{16'h7FFF, 16'hFFFF, 3'b010});
        rq0.push_back('{16'h1111, 16'h2222, 3'b110});
        rq1.push_back('{16'hF0F0, 16'h0FF0, 3'b100});
        repeat (3) @(posedge CLK);
        #2;
        check_all_zero("reset_values");
        @(posedge CLK); #3;
        Reset_n = 1'b1;
        wait_drain(200);

        // Single requester add, long hold.
        forced_hold = 3;
        rq0.push_back('{16'h000A, 16'h000B, 3'b000});
        wait_drain(100);
        forced_hold = -1;

        // Logic op with ALU reporting overflow: must be masked.
        junk_ovf = 1'b1;
        rq1.push_back('{16'h9200, 16'h079F, 3'b101});
        wait_drain(100);
        junk_ovf = 1'b0;

        // Illegal opcode.
        rq0.push_back('{16'h1234, 16'h5678, 3'b011});
        wait_drain(100);

        // Reset during EXEC with both requesting.
        rq0.push_back('{16'h0003, 16'h0004, 3'b000});
        rq0.push_back('{16'h00F0, 16'h000F, 3'b110});
        rq1.push_back('{16'h8000, 16'h0001, 3'b010});
        rq1.push_back('{16'hAAAA, 16'h5555, 3'b101});
        n = 0;
        do begin
            @(posedge CLK); #2;
            n++;
        end while (!exec_now && n < 50);
        check("reached_exec", exec_now, 1'b1);
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        model_idle = 1'b1;
        model_last = 1;
        age = 0;
        RespAck0 = 1'b0;
        RespAck1 = 1'b0;
        repeat (2) @(posedge CLK);
        #3;
        Reset_n = 1'b1;
        wait_drain(200);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            o.a  = rand_val();
            o.b  = rand_val();
            o.op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rq0.push_back(o); else rq1.push_back(o);
            junk_ovf = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 6)) @(posedge CLK);
            #2;
        end
        wait_drain(2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
